xor_result_checker: RTL and testbench

- Downstream consumer of the XOR stage. It sits on the same `demo_intf` signals (in1, in2, out1) and samples them every cycle during a run.
- Each sample is compared against the golden value in1 ^ in2.
- The block keeps match/mismatch counts and captures the first failing vector.
- It reports pass/fail when the run ends and is used as the self-checking back end of the tb_top-level benches.

---
 rtl/xor_chk_pkg.sv | 22 ++
 rtl/xor_result_checker_if.sv | 13 +
 rtl/xor_chk_counter.sv | 26 ++
 rtl/xor_result_checker.sv | 152 +++++++++++++++
 tb/tb_xor_result_checker.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/xor_chk_pkg.sv
// Shared types for the XOR result checker.
//   state_t   : checker run states
//   xor_vec_t : one sampled vector {in1, in2, out1}
//   VEC_W     : width of a packed xor_vec_t
package xor_chk_pkg;

  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic in1;
    logic in2;
    logic out1;
  } xor_vec_t;

endpackage

// File: rtl/xor_result_checker_if.sv
// Signals shared between the XOR stage and its consumers.
//   in1, in2 : XOR stage operands
//   out1     : XOR stage result
// master: the side that drives the operands/result (stimulus + XOR stage)
// slave : passive observers such as the result checker
interface demo_intf;
  logic in1;
  logic in2;
  logic out1;

  modport master (output in1, output in2, output out1);
  modport slave  (input  in1, input  in2, input  out1);
endinterface

// File: rtl/xor_chk_counter.sv
// CNT_W-wide up-counter used for the match and mismatch tallies.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   clr : synchronous clear (start of a new run)
//   en  : count enable
//   q   : current count
// The checker parameter range guarantees q never wraps within a run.
module xor_chk_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/xor_result_checker.sv
// Passive back-end checker for the XOR stage. During a run it samples
// {in1,in2,out1} on NUM_SAMPLES consecutive edges, compares each sample
// against in1 ^ in2 one edge later, tallies matches/mismatches and
// latches the first failing vector.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : one-cycle run request (honoured in IDLE or DONE)
//   intf            : demo_intf slave view (in1, in2, out1)
//   busy            : run in progress (RUN or DRAIN)
//   done, pass      : run finished; pass when no mismatch was seen
//   match_cnt       : number of matching compares
//   mismatch_cnt    : number of failing compares
//   first_err_valid : a mismatch has been captured this run
//   first_err_idx   : 0-based sample index of the first mismatch
//   first_err_vec   : {in1,in2,out1} of the first mismatch
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | capturing one sample per edge until NUM_SAMPLES are taken
// DRAIN | one extra edge so the last captured sample gets compared
// DONE  | results stable; start launches a fresh run
module xor_result_checker
  import xor_chk_pkg::*;
#(
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  demo_intf.slave          intf,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [VEC_W-1:0] first_err_vec
);

  if (NUM_SAMPLES < 1 || NUM_SAMPLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $fatal(1, "xor_result_checker: NUM_SAMPLES out of range 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t            state_q;
  state_t            state_d;
  logic              start_ok;
  logic [CNT_W-1:0]  idx_q;
  logic              cap_valid;
  logic [CNT_W-1:0]  cap_idx;
  xor_vec_t          cap_vec;
  logic              golden;
  logic              is_match;
  logic              match_en;
  logic              mismatch_en;

  // start is only meaningful when no run is in flight
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: capture the bus with its sample index
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      cap_vec   <= '0;
    end else begin
      cap_valid <= (state_q == RUN);
      if (start_ok) begin
        idx_q <= '0;
      end else if (state_q == RUN) begin
        idx_q   <= idx_q + CNT_W'(1);
        cap_idx <= idx_q;
        cap_vec <= '{in1: intf.in1, in2: intf.in2, out1: intf.out1};
      end
    end
  end

  // Stage 2: compare. Case equality makes X/Z on out1 a mismatch in
  // four-state simulation.
  assign golden      = cap_vec.in1 ^ cap_vec.in2;
  assign is_match    = (cap_vec.out1 === golden);
  assign match_en    = cap_valid && is_match;
  assign mismatch_en = cap_valid && !is_match;

  xor_chk_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (match_en),
    .q   (match_cnt)
  );

  xor_chk_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (mismatch_en),
    .q   (mismatch_cnt)
  );

  // Only the first mismatch of a run is kept
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_vec   <= '0;
    end else if (mismatch_en && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_idx   <= cap_idx;
      first_err_vec   <= cap_vec;
    end
  end

  assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_xor_result_checker.sv
module tb_xor_result_checker;
  import xor_chk_pkg::*;

  localparam int N     = 16;
  localparam int CNT_W = 8;

  typedef struct {
    int          m;
    int          mm;
    logic        fv;
    int          fi;
    logic [2:0]  fvec;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             first_err_valid;
  logic [CNT_W-1:0] first_err_idx;
  logic [VEC_W-1:0] first_err_vec;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  demo_intf intf ();

  xor_result_checker #(.NUM_SAMPLES(N), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .intf            (intf.slave),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .match_cnt       (match_cnt),
    .mismatch_cnt    (mismatch_cnt),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .first_err_vec   (first_err_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_pass"}, 32'(pass), 0);
    check_eq({tag, "_match"}, 32'(match_cnt), 0);
    check_eq({tag, "_mismatch"}, 32'(mismatch_cnt), 0);
    check_eq({tag, "_fe_valid"}, 32'(first_err_valid), 0);
    check_eq({tag, "_fe_idx"}, 32'(first_err_idx), 0);
    check_eq({tag, "_fe_vec"}, 32'(first_err_vec), 0);
  endtask

  // One run: start, N samples of the 00,01,10,11 pattern with the bench
  // acting as the XOR stage, optional faults, start pulses and reset.
  task automatic do_run(input string tag, input logic [31:0] flip_m,
                        input logic [31:0] x_m, input logic [31:0] start_m,
                        input int rst_at);
    exp_t e;
    exp_t got;
    int   start_cyc;
    int   n;
    int   last_mis;
    logic a, b, o, g;
    e = '{m: 0, mm: 0, fv: 1'b0, fi: 0, fvec: 3'b000};
    last_mis = 0;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    check_eq({tag, "_clr_match"}, 32'(match_cnt), 0);
    check_eq({tag, "_clr_mismatch"}, 32'(mismatch_cnt), 0);
    check_eq({tag, "_clr_fe_valid"}, 32'(first_err_valid), 0);
    check_eq({tag, "_busy"}, 32'(busy), 1);
    for (int i = 0; i < N; i++) begin
      a = 1'(i[1]);
      b = 1'(i[0]);
      g = a ^ b;
      o = g;
      if (flip_m[i]) o = ~g;
      if (x_m[i]) o = 1'bx;
      intf.in1  = a;
      intf.in2  = b;
      intf.out1 = o;
      if (i == rst_at) begin
        check_eq({tag, "_pre_rst_mismatch"}, 32'(mismatch_cnt), 32'(e.mm - last_mis));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero({tag, "_rst"});
        tick();
        check_all_zero({tag, "_idle"});
        return;
      end
      start = start_m[i];
      tick();
      start = 1'b0;
      if (o === g) begin
        e.m++;
        last_mis = 0;
      end else begin
        if (!e.fv) begin
          e.fv   = 1'b1;
          e.fi   = i;
          e.fvec = {a, b, o};
        end
        e.mm++;
        last_mis = 1;
      end
    end
    sb.push_back(e);
    check_eq({tag, "_not_done_yet"}, 32'(done), 0);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done), 1);
    // start edge counts as the first of the N+2 edges
    check_eq({tag, "_done_lat"}, 32'(cyc - start_cyc), 32'(N + 2));
    got = sb.pop_front();
    check_eq({tag, "_match"}, 32'(match_cnt), 32'(got.m));
    check_eq({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(got.mm));
    check_eq({tag, "_sum"}, 32'(match_cnt) + 32'(mismatch_cnt), 32'(N));
    check_eq({tag, "_pass"}, 32'(pass), 32'(got.mm == 0));
    check_eq({tag, "_busy_end"}, 32'(busy), 0);
    check_eq({tag, "_fe_valid"}, 32'(first_err_valid), 32'(got.fv));
    if (got.fv) begin
      check_eq({tag, "_fe_idx"}, 32'(first_err_idx), 32'(got.fi));
      check_eq({tag, "_fe_vec"}, 32'(first_err_vec), 32'(got.fvec));
    end
    tick();
    check_eq({tag, "_done_hold"}, 32'(done), 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    intf.in1  = 1'b0;
    intf.in2  = 1'b0;
    intf.out1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      intf.in1  = 1'($urandom_range(0, 1));
      intf.in2  = 1'($urandom_range(0, 1));
      intf.out1 = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      tick();
    end
    check_all_zero("reset");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_all_zero("idle");

    do_run("clean",   32'h0, 32'h0, 32'h0, -1);
    do_run("fault5",  32'h0000_0020, 32'h0, 32'h0, -1);
    do_run("multi",   32'h0000_0204, 32'h0000_1000, 32'h0, -1);
    do_run("busy_st", 32'h0, 32'h0, 32'h0000_0408, -1);
    do_run("restart", 32'h0, 32'h0, 32'h0, -1);
    do_run("rst_mid", 32'h0000_0012, 32'h0, 32'h0, 7);
    do_run("fresh",   32'h0, 32'h0, 32'h0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
